// File: rtl/fetch_unit_if.sv
// Fetch stage bundle: start/done handshake, control-unit redirect inputs,
// instruction ROM port and the instruction/PC outputs toward the control unit.
interface fetch_unit_if #(
   parameter int PC_W    = 10,
   parameter int INSTR_W = 9,
   parameter int CNT_W   = 16
);
   logic               start;
   logic               stall;
   logic               branch_en;
   logic [PC_W-1:0]    branch_target;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic [PC_W-1:0]    pc;
   logic               done;
   logic [CNT_W-1:0]   cycle_count;

   modport master (
      input  start, stall, branch_en, branch_target, imem_rdata,
      output imem_addr, instr, instr_valid, pc, done, cycle_count
   );

   modport slave (
      output start, stall, branch_en, branch_target, imem_rdata,
      input  imem_addr, instr, instr_valid, pc, done, cycle_count
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction ROM and
// presents one instruction per cycle with zero-penalty branch redirect.
module fetch_unit #(
   parameter int                 PC_W       = 10,
   parameter int                 INSTR_W    = 9,
   parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF,
   parameter int                 CNT_W      = 16
) (
   input logic          clk,
   input logic          rst_n,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {IDLE, PRIME, RUN, HALTED} state_t;

   state_t           state, next_state;
   logic [PC_W-1:0]  pc_q, next_pc;
   logic [CNT_W-1:0] count_q;
   logic             is_halt, at_end;

   // pc_q always names the address whose data is on imem_rdata this cycle.
   assign is_halt = (bus.imem_rdata == HALT_INSTR);
   assign at_end  = (pc_q == {PC_W{1'b1}});

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples the pre-edge values; combinational blocks use blocking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // NOTE: every combinational output gets a default before the case so no
   // path leaves a signal unassigned, which would infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = PRIME;
         PRIME:   next_state = RUN;
         RUN: begin
            if (is_halt)
               next_state = HALTED;
            else if (!bus.stall && !bus.branch_en && at_end)
               next_state = HALTED;
         end
         HALTED:  if (bus.start) next_state = PRIME;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      next_pc         = pc_q;
      bus.imem_addr   = '0;
      bus.instr       = '0;
      bus.instr_valid = 1'b0;
      bus.done        = 1'b0;
      case (state)
         RUN: begin
            bus.instr = bus.imem_rdata;
            if (!is_halt) begin
               bus.instr_valid = 1'b1;
               // Stall beats branch; the last address holds rather than wrapping.
               if (bus.stall)          next_pc = pc_q;
               else if (bus.branch_en) next_pc = bus.branch_target;
               else if (!at_end)       next_pc = pc_q + 1'b1;
            end
            bus.imem_addr = next_pc;
         end
         HALTED: begin
            bus.done      = 1'b1;
            bus.imem_addr = pc_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= '0;
         count_q <= '0;
      end else begin
         case (state)
            IDLE, HALTED: if (bus.start) count_q <= '0;
            PRIME:        pc_q <= '0;
            RUN: begin
               pc_q <= next_pc;
               if (count_q != {CNT_W{1'b1}}) count_q <= count_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.pc          = pc_q;
   assign bus.cycle_count = count_q;

endmodule
